// File: rtl/fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : fifo_burst_reader
// Purpose  : Collects single FIFO beats into a buffer and emits them as bursts
//            of up to BURST_LEN beats with last marker and length tag.
//            Optional macro: BURST_TIMEOUT_EN (input-idle timeout flush).
// Revision : 1.0 - initial release
// ============================================================================
module fifo_burst_reader #(
    parameter int DATA_WIDTH = 32,
    parameter int BURST_LEN  = 8,
    parameter int TIMEOUT    = 16
) (
    input  logic                           clk,
    input  logic                           arst_n,
    input  logic                           in_vld_i,
    output logic                           in_rdy_o,
    input  logic [DATA_WIDTH-1:0]          in_data_i,
    output logic                           out_vld_o,
    input  logic                           out_rdy_i,
    output logic [DATA_WIDTH-1:0]          out_data_o,
    output logic                           out_last_o,
    output logic [$clog2(BURST_LEN+1)-1:0] out_len_o,
    input  logic                           flush_i,
    output logic                           busy_o
);

    localparam int CNT_W = $clog2(BURST_LEN + 1);
    localparam int IDX_W = $clog2(BURST_LEN);
    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(BURST_LEN - 1);

    if (BURST_LEN < 2 || TIMEOUT < 1) begin : g_param_check
        $error("fifo_burst_reader: BURST_LEN must be >= 2 and TIMEOUT >= 1");
    end

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_FILL  = 2'd1,
        ST_DRAIN = 2'd2
    } state_t;

    state_t                state;
    state_t                state_nxt;
    logic [CNT_W-1:0]      cnt;
    logic [CNT_W-1:0]      cnt_nxt;
    logic [CNT_W-1:0]      rd_idx;
    logic [CNT_W-1:0]      rd_idx_nxt;
    logic                  wr_en;
    logic                  in_acc;
    logic                  out_acc;
    logic                  timeout_hit;
    logic [DATA_WIDTH-1:0] buf_mem [BURST_LEN];

    // ------------------------------------------------------------------------
    // Outputs depend only on state, so both handshakes are free of
    // combinational paths from the opposite side.
    // ------------------------------------------------------------------------
    always_comb begin
        in_rdy_o   = (state != ST_DRAIN);
        out_vld_o  = (state == ST_DRAIN);
        busy_o     = (state != ST_IDLE);
        out_len_o  = out_vld_o ? cnt : '0;
        out_last_o = out_vld_o && (rd_idx == (cnt - 1'b1));
        out_data_o = buf_mem[rd_idx[IDX_W-1:0]];
    end

    assign in_acc  = in_vld_i && in_rdy_o;
    assign out_acc = out_vld_o && out_rdy_i;

`ifdef BURST_TIMEOUT_EN
    localparam int TMR_W = $clog2(TIMEOUT + 1);
    localparam logic [TMR_W-1:0] TMR_LAST = TMR_W'(TIMEOUT - 1);

    logic [TMR_W-1:0] tmr;
    logic [TMR_W-1:0] tmr_nxt;

    // Expiry fires in the cycle the timer would step onto TIMEOUT; a beat
    // accepted in that same cycle takes precedence.
    assign timeout_hit = (state == ST_FILL) && !in_acc && (tmr == TMR_LAST);

    always_comb begin
        tmr_nxt = '0;
        if (state == ST_FILL && !in_acc) begin
            tmr_nxt = tmr + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            tmr <= '0;
        end else begin
            tmr <= tmr_nxt;
        end
    end
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_nxt  = state;
        cnt_nxt    = cnt;
        rd_idx_nxt = rd_idx;
        wr_en      = 1'b0;
        case (state)
            ST_IDLE: begin
                if (in_acc) begin
                    wr_en     = 1'b1;
                    cnt_nxt   = CNT_W'(1);
                    state_nxt = ST_FILL;
                end
            end
            ST_FILL: begin
                if (in_acc) begin
                    wr_en   = 1'b1;
                    cnt_nxt = cnt + 1'b1;
                end
                if ((in_acc && cnt == LAST_CNT) || flush_i || timeout_hit) begin
                    state_nxt = ST_DRAIN;
                end
            end
            ST_DRAIN: begin
                if (out_acc) begin
                    if (out_last_o) begin
                        state_nxt  = ST_IDLE;
                        cnt_nxt    = '0;
                        rd_idx_nxt = '0;
                    end else begin
                        rd_idx_nxt = rd_idx + 1'b1;
                    end
                end
            end
            default: begin
                state_nxt  = ST_IDLE;
                cnt_nxt    = '0;
                rd_idx_nxt = '0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state  <= ST_IDLE;
            cnt    <= '0;
            rd_idx <= '0;
        end else begin
            state  <= state_nxt;
            cnt    <= cnt_nxt;
            rd_idx <= rd_idx_nxt;
        end
    end

    // Payload storage needs no reset; cnt/rd_idx decide what is valid.
    always_ff @(posedge clk) begin
        if (arst_n && wr_en) begin
            buf_mem[cnt[IDX_W-1:0]] <= in_data_i;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_fifo_burst_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_fifo_burst_reader
// Purpose  : Directed self-checking bench for fifo_burst_reader.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_fifo_burst_reader;

    logic        clk = 1'b0;
    logic        arst_n;
    logic        in_vld_i;
    logic        in_rdy_o;
    logic [31:0] in_data_i;
    logic        out_vld_o;
    logic        out_rdy_i;
    logic [31:0] out_data_o;
    logic        out_last_o;
    logic [3:0]  out_len_o;
    logic        flush_i;
    logic        busy_o;

    int n_checks = 0;
    int n_fail   = 0;

    fifo_burst_reader #(
        .DATA_WIDTH(32),
        .BURST_LEN (8),
        .TIMEOUT   (16)
    ) dut (
        .clk        (clk),
        .arst_n     (arst_n),
        .in_vld_i   (in_vld_i),
        .in_rdy_o   (in_rdy_o),
        .in_data_i  (in_data_i),
        .out_vld_o  (out_vld_o),
        .out_rdy_i  (out_rdy_i),
        .out_data_o (out_data_o),
        .out_last_o (out_last_o),
        .out_len_o  (out_len_o),
        .flush_i    (flush_i),
        .busy_o     (busy_o)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Stimulus only: presents n consecutive beats, flush optionally on the last.
    task automatic load_beats(input logic [31:0] base, input int n, input bit flush_last);
        for (int i = 0; i < n; i++) begin
            in_vld_i  = 1'b1;
            in_data_i = base + 32'(i);
            flush_i   = flush_last && (i == n - 1);
            tick();
        end
        in_vld_i = 1'b0;
        flush_i  = 1'b0;
    endtask

    task automatic test_reset();
        arst_n    = 1'b0;
        in_vld_i  = 1'b1;
        in_data_i = 32'hDEAD_BEEF;
        out_rdy_i = 1'b1;
        flush_i   = 1'b0;
        repeat (2) tick();
        n_checks++;
        if (out_vld_o !== 1'b0 || busy_o !== 1'b0 || in_rdy_o !== 1'b1 ||
            out_len_o !== 4'd0 || out_last_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_values: vld=%b busy=%b rdy=%b len=%0d last=%b required 0 0 1 0 0",
                     out_vld_o, busy_o, in_rdy_o, out_len_o, out_last_o);
        end
        arst_n   = 1'b1;
        in_vld_i = 1'b0;
        tick();
        n_checks++;
        if (busy_o !== 1'b0 || out_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_no_capture: busy=%b vld=%b required 0 0", busy_o, out_vld_o);
        end
    endtask

    task automatic test_full_burst();
        out_rdy_i = 1'b1;
        for (int i = 0; i < 8; i++) begin
            in_vld_i  = 1'b1;
            in_data_i = 32'h100 + 32'(i);
            n_checks++;
            if (in_rdy_o !== 1'b1 || out_vld_o !== 1'b0) begin
                n_fail++;
                $display("FAIL full_fill_rdy[%0d]: rdy=%b vld=%b required 1 0", i, in_rdy_o, out_vld_o);
            end
            tick();
        end
        in_vld_i = 1'b0;
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 32'h100 + 32'(j) ||
                out_last_o !== (j == 7) || out_len_o !== 4'd8 || in_rdy_o !== 1'b0) begin
                n_fail++;
                $display("FAIL full_beat[%0d]: vld=%b data=%h last=%b len=%0d rdy=%b required 1 %h %b 8 0",
                         j, out_vld_o, out_data_o, out_last_o, out_len_o, in_rdy_o,
                         32'h100 + 32'(j), (j == 7));
            end
            tick();
        end
        n_checks++;
        if (out_vld_o !== 1'b0 || in_rdy_o !== 1'b1 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL full_done: vld=%b rdy=%b busy=%b required 0 1 0", out_vld_o, in_rdy_o, busy_o);
        end
    endtask

    task automatic test_backpressure();
        int j;
        out_rdy_i = 1'b0;
        load_beats(32'h100, 8, 1'b0);
        j = 0;
        for (int c = 0; c < 40 && j < 8; c++) begin
            out_rdy_i = (c % 2 == 0);
            n_checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 32'h100 + 32'(j) ||
                out_last_o !== (j == 7) || out_len_o !== 4'd8) begin
                n_fail++;
                $display("FAIL bp_beat[%0d] cyc %0d: vld=%b data=%h last=%b len=%0d required 1 %h %b 8",
                         j, c, out_vld_o, out_data_o, out_last_o, out_len_o,
                         32'h100 + 32'(j), (j == 7));
            end
            if (out_rdy_i) j++;
            tick();
        end
        out_rdy_i = 1'b1;
        n_checks++;
        if (j != 8 || out_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL bp_done: beats=%0d vld=%b required 8 0", j, out_vld_o);
        end
    endtask

    task automatic test_timeout();
        out_rdy_i = 1'b1;
        load_beats(32'hA, 3, 1'b0);
`ifdef BURST_TIMEOUT_EN
        begin
            int k;
            k = 1;
            while (!out_vld_o && k < 40) begin
                tick();
                k++;
            end
            n_checks++;
            if (k != 17) begin
                n_fail++;
                $display("FAIL timeout_latency: cycles=%0d required 17", k);
            end
        end
`else
        begin
            bit seen_vld;
            seen_vld = 1'b0;
            repeat (20) begin
                if (out_vld_o) seen_vld = 1'b1;
                tick();
            end
            n_checks++;
            if (seen_vld || busy_o !== 1'b1) begin
                n_fail++;
                $display("FAIL no_timeout_wait: seen_vld=%b busy=%b required 0 1", seen_vld, busy_o);
            end
            flush_i = 1'b1;
            tick();
            flush_i = 1'b0;
        end
`endif
        for (int j = 0; j < 3; j++) begin
            n_checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 32'hA + 32'(j) ||
                out_last_o !== (j == 2) || out_len_o !== 4'd3) begin
                n_fail++;
                $display("FAIL partial_beat[%0d]: vld=%b data=%h last=%b len=%0d required 1 %h %b 3",
                         j, out_vld_o, out_data_o, out_last_o, out_len_o, 32'hA + 32'(j), (j == 2));
            end
            tick();
        end
        n_checks++;
        if (out_vld_o !== 1'b0 || busy_o !== 1'b0) begin
            n_fail++;
            $display("FAIL partial_done: vld=%b busy=%b required 0 0", out_vld_o, busy_o);
        end
    endtask

    task automatic test_flush();
        out_rdy_i = 1'b1;
        load_beats(32'h50, 5, 1'b1);
        for (int j = 0; j < 5; j++) begin
            n_checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 32'h50 + 32'(j) ||
                out_last_o !== (j == 4) || out_len_o !== 4'd5) begin
                n_fail++;
                $display("FAIL flush_beat[%0d]: vld=%b data=%h last=%b len=%0d required 1 %h %b 5",
                         j, out_vld_o, out_data_o, out_last_o, out_len_o, 32'h50 + 32'(j), (j == 4));
            end
            tick();
        end
        flush_i = 1'b1;
        repeat (2) begin
            tick();
            n_checks++;
            if (busy_o !== 1'b0 || out_vld_o !== 1'b0) begin
                n_fail++;
                $display("FAIL flush_idle: busy=%b vld=%b required 0 0", busy_o, out_vld_o);
            end
        end
        flush_i = 1'b0;
    endtask

    task automatic test_reset_mid_drain();
        out_rdy_i = 1'b1;
        load_beats(32'h200, 8, 1'b0);
        for (int j = 0; j < 2; j++) begin
            n_checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 32'h200 + 32'(j)) begin
                n_fail++;
                $display("FAIL abort_beat[%0d]: vld=%b data=%h required 1 %h",
                         j, out_vld_o, out_data_o, 32'h200 + 32'(j));
            end
            tick();
        end
        arst_n = 1'b0;
        tick();
        n_checks++;
        if (out_vld_o !== 1'b0 || busy_o !== 1'b0 || in_rdy_o !== 1'b1 || out_len_o !== 4'd0) begin
            n_fail++;
            $display("FAIL abort_reset: vld=%b busy=%b rdy=%b len=%0d required 0 0 1 0",
                     out_vld_o, busy_o, in_rdy_o, out_len_o);
        end
        arst_n = 1'b1;
        load_beats(32'h300, 8, 1'b0);
        for (int j = 0; j < 8; j++) begin
            n_checks++;
            if (out_vld_o !== 1'b1 || out_data_o !== 32'h300 + 32'(j) ||
                out_last_o !== (j == 7) || out_len_o !== 4'd8) begin
                n_fail++;
                $display("FAIL after_abort_beat[%0d]: vld=%b data=%h last=%b len=%0d required 1 %h %b 8",
                         j, out_vld_o, out_data_o, out_last_o, out_len_o, 32'h300 + 32'(j), (j == 7));
            end
            tick();
        end
        n_checks++;
        if (out_vld_o !== 1'b0) begin
            n_fail++;
            $display("FAIL after_abort_done: vld=%b required 0", out_vld_o);
        end
    endtask

    initial begin
        test_reset();
        test_full_burst();
        test_backpressure();
        test_timeout();
        test_flush();
        test_reset_mid_drain();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, required completion");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire
